// File: rtl/eth_pcs_rx_block_sync_pkg.sv
// Shared 10GBASE-R PCS receive constants and the block-sync FSM state type.
// Also provides the sync-header validity helper used by the block-sync logic.
package eth_pcs_params;

  localparam int unsigned W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  // 64 headers per test window; 16 bad headers in one window force a slip.
  localparam int unsigned SH_VAL_TH = 64;
  localparam int unsigned SH_INVAL_TH = 16;
  localparam int unsigned W_SH_VAL_TH = $clog2(SH_VAL_TH);
  localparam int unsigned W_SH_INVAL_TH = $clog2(SH_INVAL_TH);

  typedef enum logic [1:0] {
    StLockInit,
    StResetCnt,
    StTestSh,
    StSlipWait
  } blk_sync_state_e;

  function automatic logic sh_valid(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_sync_if.sv
// Gearbox <-> block-sync link: sync header stream in, slip request and lock status out.
interface eth_pcs_rx_block_sync_if;
  import eth_pcs_params::*;

  logic [W_SYNC-1:0] hdr;
  logic              hdr_vld;
  logic              slip;
  logic              block_lock;

  // Gearbox side.
  modport master (
    output hdr,
    output hdr_vld,
    input  slip,
    input  block_lock
  );

  // Block-sync side.
  modport slave (
    input  hdr,
    input  hdr_vld,
    output slip,
    output block_lock
  );

endinterface

// File: rtl/eth_pcs_rx_block_sync.sv
// 66-bit block alignment FSM: tests sync headers per 64-header window and requests
// single-bit gearbox slips until a clean window is seen.
module eth_pcs_rx_block_sync
  import eth_pcs_params::*;
#(
  parameter int unsigned SLIP_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_SYNC-1:0] i_hdr,
  input  logic              i_hdr_vld,
  output logic              o_slip,
  output logic              o_block_lock
);

  localparam int unsigned WaitW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);
  localparam logic [W_SH_VAL_TH-1:0] ShLast = W_SH_VAL_TH'(SH_VAL_TH - 1);
  localparam logic [W_SH_INVAL_TH-1:0] InvLast = W_SH_INVAL_TH'(SH_INVAL_TH - 1);

  blk_sync_state_e          state_q, state_d;
  logic [W_SH_VAL_TH-1:0]   sh_cnt_q, sh_cnt_d;
  logic [W_SH_INVAL_TH-1:0] inv_cnt_q, inv_cnt_d;
  logic [WaitW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                     slip_q, slip_d;
  logic                     lock_q, lock_d;

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;

    unique case (state_q)
      StLockInit: begin
        lock_d  = 1'b0;
        state_d = StResetCnt;
      end

      StResetCnt: begin
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
        state_d   = StTestSh;
      end

      StTestSh: begin
        if (i_hdr_vld) begin
          if (sh_valid(i_hdr)) begin
            if (sh_cnt_q == ShLast) begin
              if (inv_cnt_q == '0) lock_d = 1'b1;
              state_d = StResetCnt;
            end else begin
              sh_cnt_d = sh_cnt_q + 1'b1;
            end
          end else if (!lock_q || (inv_cnt_q == InvLast)) begin
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            wait_cnt_d = '0;
            state_d    = StSlipWait;
          end else if (sh_cnt_q == ShLast) begin
            state_d = StResetCnt;
          end else begin
            sh_cnt_d  = sh_cnt_q + 1'b1;
            inv_cnt_d = inv_cnt_q + 1'b1;
          end
        end
      end

      StSlipWait: begin
        // Headers seen here come from a gearbox that is still re-aligning.
        if (SLIP_WAIT == 0) begin
          state_d = StResetCnt;
        end else if (i_hdr_vld) begin
          if (wait_cnt_q == WaitLast) begin
            wait_cnt_d = '0;
            state_d    = StResetCnt;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StLockInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLockInit;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Directed bench for eth_pcs_rx_block_sync: lock acquisition, slips, loss of lock,
// reset precedence and sparse header strobes.
module tb_eth_pcs_rx_block_sync;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   slip_cnt;

  eth_pcs_rx_block_sync_if bus ();

  eth_pcs_rx_block_sync #(
    .SLIP_WAIT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_hdr       (bus.hdr),
    .i_hdr_vld   (bus.hdr_vld),
    .o_slip      (bus.slip),
    .o_block_lock(bus.block_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle o_slip is high is counted once, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.slip === 1'b1) slip_cnt <= slip_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied at negedge, outputs sampled 1ns after the rising edge.
  task automatic step(input logic v, input logic [1:0] h, input logic r);
    @(negedge clk);
    bus.hdr_vld = v;
    bus.hdr     = h;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  task automatic send_valid(input int n);
    for (int i = 0; i < n; i++) step(1'b1, (i % 2 == 1) ? 2'b10 : 2'b01, 1'b0);
  endtask

  // Two reset edges, then two free edges to pass LOCK_INIT and RESET_CNT.
  task automatic do_reset();
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    idle(2);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    slip_cnt    = 0;
    rst         = 1'b1;
    bus.hdr_vld = 1'b0;
    bus.hdr     = 2'b00;

    // Reset state.
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    check("rst_lock", {31'd0, bus.block_lock}, 32'd0);
    check("rst_slip", {31'd0, bus.slip}, 32'd0);
    idle(2);

    // 64 clean headers lock on the 64th strobe.
    send_valid(63);
    check("acq_lock_63", {31'd0, bus.block_lock}, 32'd0);
    send_valid(1);
    check("acq_lock_64", {31'd0, bus.block_lock}, 32'd1);
    check("acq_no_slip", slip_cnt, 32'd0);
    idle(1);

    // Locked: 15 invalid headers in one window are tolerated.
    for (int i = 0; i < 64; i++) begin
      if ((i % 4 == 0) && (i < 60)) step(1'b1, (i % 8 == 0) ? 2'b11 : 2'b00, 1'b0);
      else step(1'b1, 2'b01, 1'b0);
    end
    check("inv15_lock", {31'd0, bus.block_lock}, 32'd1);
    check("inv15_no_slip", slip_cnt, 32'd0);
    idle(1);
    send_valid(64);
    check("clean_win_lock", {31'd0, bus.block_lock}, 32'd1);
    check("clean_win_no_slip", slip_cnt, 32'd0);
    idle(1);

    // Locked: the 16th invalid header in a window drops lock and slips.
    for (int i = 0; i <= 60; i++) begin
      step(1'b1, (i % 4 == 0) ? 2'b11 : 2'b10, 1'b0);
    end
    check("inv16_lock", {31'd0, bus.block_lock}, 32'd0);
    check("inv16_slip", {31'd0, bus.slip}, 32'd1);
    idle(1);
    check("inv16_slip_pulse", {31'd0, bus.slip}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 1'b0);
    idle(1);
    send_valid(63);
    check("relock_63", {31'd0, bus.block_lock}, 32'd0);
    send_valid(1);
    check("relock_64", {31'd0, bus.block_lock}, 32'd1);
    check("relock_slips", slip_cnt, 32'd1);
    idle(1);

    // Reset while locked wins immediately.
    step(1'b1, 2'b01, 1'b1);
    check("rst_locked", {31'd0, bus.block_lock}, 32'd0);
    idle(2);

    // Unlocked: first bad header slips; the next four strobes are discarded.
    step(1'b1, 2'b11, 1'b0);
    check("unl_slip", {31'd0, bus.slip}, 32'd1);
    check("unl_lock", {31'd0, bus.block_lock}, 32'd0);
    step(1'b1, 2'b11, 1'b0);
    check("unl_slip_pulse", {31'd0, bus.slip}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0);
    idle(1);
    check("wait_no_reslip", slip_cnt, 32'd2);
    send_valid(63);
    check("unl_relock_63", {31'd0, bus.block_lock}, 32'd0);
    send_valid(1);
    check("unl_relock_64", {31'd0, bus.block_lock}, 32'd1);

    // Reset on the cycle of the 64th header suppresses lock; counting restarts.
    do_reset();
    send_valid(63);
    step(1'b1, 2'b10, 1'b1);
    check("rst64_lock", {31'd0, bus.block_lock}, 32'd0);
    idle(2);
    send_valid(63);
    check("rst64_restart_63", {31'd0, bus.block_lock}, 32'd0);
    send_valid(1);
    check("rst64_restart_64", {31'd0, bus.block_lock}, 32'd1);

    // Sparse strobes: one header every three cycles.
    do_reset();
    for (int i = 0; i < 63; i++) begin
      step(1'b1, (i % 2 == 1) ? 2'b10 : 2'b01, 1'b0);
      idle(2);
    end
    check("sparse_63", {31'd0, bus.block_lock}, 32'd0);
    step(1'b1, 2'b10, 1'b0);
    check("sparse_64", {31'd0, bus.block_lock}, 32'd1);
    idle(2);
    check("sparse_hold", {31'd0, bus.block_lock}, 32'd1);
    check("total_slips", slip_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_block_sync.md
ETH_PCS_RX_BLOCK_SYNC -- requirements
Module: eth_pcs_rx_block_sync

Interface
REQ-001 The block SHALL have parameter SLIP_WAIT, default 4, meaning the number of i_hdr_vld strobes ignored after each slip while the RX gearbox settles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_hdr, input, W_SYNC bits: the sync header of the current 66-bit block from the RX gearbox.
REQ-005 The block SHALL have port i_hdr_vld, input, 1 bit: i_hdr is valid this cycle; at most one header per strobe.
REQ-006 The block SHALL have port o_slip, output, 1 bit: one-cycle pulse telling the RX gearbox to shift its alignment by one bit.
REQ-007 The block SHALL have port o_block_lock, output, 1 bit: 66-bit block alignment is achieved.

Function
REQ-008 A header SHALL be valid when i_hdr equals SYNC_DATA or SYNC_CTRL; 2'b00 and 2'b11 SHALL be invalid.
REQ-009 The FSM SHALL have states LOCK_INIT, RESET_CNT, TEST_SH and SLIP_WAIT_ST; all counters and state advance only on i_hdr_vld, except the LOCK_INIT->RESET_CNT and RESET_CNT->TEST_SH transitions, which take one clock each unconditionally.
REQ-010 LOCK_INIT SHALL clear o_block_lock and go to RESET_CNT.
REQ-011 RESET_CNT SHALL clear sh_cnt (W_SH_VAL_TH bits) and inv_cnt (W_SH_INVAL_TH bits) and go to TEST_SH.
REQ-012 In TEST_SH, on each i_hdr_vld, sh_cnt SHALL increment by one; an invalid header SHALL also increment inv_cnt.
REQ-013 On a valid header with sh_cnt==SH_VAL_TH-1 (64th header) and inv_cnt==0, the block SHALL set o_block_lock and go to RESET_CNT.
REQ-014 On a valid header with sh_cnt==SH_VAL_TH-1 and inv_cnt>0, the block SHALL go to RESET_CNT with o_block_lock unchanged.
REQ-015 On an invalid header when o_block_lock==0, or when inv_cnt==SH_INVAL_TH-1 (16th invalid), the block SHALL clear o_block_lock, assert o_slip for exactly one cycle and enter SLIP_WAIT_ST.
REQ-016 On an invalid header not meeting REQ-015 with sh_cnt==SH_VAL_TH-1, the block SHALL go to RESET_CNT with lock kept; otherwise it stays in TEST_SH.
REQ-017 SLIP_WAIT_ST SHALL discard SLIP_WAIT i_hdr_vld strobes (wait counter width $clog2(SLIP_WAIT+1)), then go to RESET_CNT; SLIP_WAIT==0 SHALL go to RESET_CNT the next cycle.
REQ-018 i_hdr_vld arriving in LOCK_INIT or RESET_CNT SHALL be ignored and not counted.
REQ-019 Counters SHALL never wrap; REQ-013..016 reset them before overflow.
REQ-020 o_slip and o_block_lock SHALL be registered outputs; o_slip SHALL assert the cycle after the triggering i_hdr_vld.

Reset
REQ-021 While rst is high at a clock edge: state=LOCK_INIT, sh_cnt=0, inv_cnt=0, wait counter=0, o_slip=0, o_block_lock=0.
REQ-022 rst asserted mid-window, mid-slip or while locked SHALL take precedence over all other events in that cycle.

Structure
REQ-023 SH_VAL_TH, SH_INVAL_TH, their widths, W_SYNC, SYNC_DATA and SYNC_CTRL SHALL come from eth_pcs_params; the FSM state enum SHALL be added there as a typedef.
REQ-024 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-025 Reset, then 64 valid headers (alternating 01/10) -> o_block_lock rises the cycle after the 64th strobe, o_slip never pulses.
REQ-026 Unlocked, first header 2'b11 -> o_slip high for one cycle; the next 4 strobes are ignored; then 64 valid headers -> lock.
REQ-027 Locked, 15 invalid headers spread within one 64-header window -> lock held, no slip; the next window has 0 invalid -> lock held.
REQ-028 Locked, 16 invalid headers within one window -> on the 16th, o_block_lock falls and o_slip pulses once.
REQ-029 rst asserted on the cycle of the 64th valid header -> o_block_lock stays 0 and the counters restart from 0.
REQ-030 i_hdr_vld gaps (strobes 1 in 3 cycles) with 64 valid headers -> lock is achieved after exactly 64 strobes, and idle cycles are not counted.
